dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the team's dual-port byte RAM (`dualportmem`) among `NREQ` requesters. Each requester issues single read or write commands over a valid/ready handshake. The arbiter registers the winning command onto the RAM port signals and routes the read data back to the requester that issued it. One instance sits in front of each RAM port that needs sharing.

---
 rtl/dpram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dpram_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one dualportmem port among NREQ requesters.
// Define DPRAM_ARB_LOCK_EN to honour req_lock (LOCKED state for atomic sequences/bursts).
module dpram_port_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [DATA_W-1:0]      mem_data,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_wr_en,
  output logic                   mem_chipselect,
  output logic                   mem_outenable,
  input  logic [DATA_W-1:0]      mem_dataout
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   tag1;
  logic [NREQ-1:0]   tag2;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DPRAM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t           state;
  logic [PTR_W-1:0] lock_owner;
  logic             sel_lock;

  assign sel_lock = req_lock[grant_idx];
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
`endif

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
`ifdef DPRAM_ARB_LOCK_EN
    if (state == LOCKED) begin
      grant_idx = lock_owner;
      found     = req_valid[lock_owner];
    end
`endif
    if (reset) begin
      found = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];
  assign next_ptr  = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= '0;
      mem_chipselect <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_outenable  <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
      tag1           <= '0;
      tag2           <= '0;
`ifdef DPRAM_ARB_LOCK_EN
      state          <= ARB;
      lock_owner     <= '0;
`endif
    end else begin
      mem_chipselect <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_outenable  <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
      tag1           <= '0;
      tag2           <= tag1;
      if (found) begin
        ptr            <= next_ptr;
        mem_chipselect <= 1'b1;
        mem_wr_en      <= sel_we;
        mem_outenable  <= !sel_we;
        mem_address    <= sel_addr;
        mem_data       <= sel_we ? sel_wdata : '0;
        if (!sel_we) begin
          tag1 <= grant;
        end
`ifdef DPRAM_ARB_LOCK_EN
        if (state == ARB && sel_lock) begin
          state      <= LOCKED;
          lock_owner <= grant_idx;
        end else if (state == LOCKED && !sel_lock) begin
          state <= ARB;
        end
`endif
      end
    end
  end

  // Owner tags run alongside the RAM's registered read, so data and tag align.
  assign rsp_valid = tag2;
  assign rsp_data  = (|tag2) ? mem_dataout : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner search, ordered shadow memory, fixed read latency).
module tb_dpram_port_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [DATA_W-1:0]      mem_data;
  logic [ADDR_W-1:0]      mem_address;
  logic                   mem_wr_en;
  logic                   mem_chipselect;
  logic                   mem_outenable;
  logic [DATA_W-1:0]      mem_dataout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_data(mem_data), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_chipselect(mem_chipselect), .mem_outenable(mem_outenable),
    .mem_dataout(mem_dataout)
  );

  // Behavioural dualportmem port: registered read, one cycle.
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_wr_en) ram[mem_address] <= mem_data;
      else if (mem_outenable) ram_q <= ram[mem_address];
    end
  end
  assign mem_dataout = ram_q;

  // Reference model: commands take effect in grant order on a shadow memory.
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  int                m_ptr = 0;
  bit                m_locked = 0;
  int                m_owner = 0;
  logic              e_cs = 0, e_we = 0, e_oe = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  logic [NREQ-1:0]   e_rv1 = '0, e_rv2 = '0;
  logic [DATA_W-1:0] e_rd1 = '0, e_rd2 = '0;

  function automatic int model_winner();
    if (reset) return -1;
`ifdef DPRAM_ARB_LOCK_EN
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_b
    int                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we;
    w = model_winner();
    e_rv2 = e_rv1; e_rd2 = e_rd1; e_rv1 = '0; e_rd1 = '0;
    e_cs = 0; e_we = 0; e_oe = 0; e_addr = '0; e_data = '0;
    if (reset) begin
      m_ptr = 0; m_locked = 0; e_rv2 = '0; e_rd2 = '0;
    end else if (w >= 0) begin
      a  = req_addr[w*ADDR_W +: ADDR_W];
      d  = req_wdata[w*DATA_W +: DATA_W];
      we = req_we[w];
      e_cs = 1; e_we = we; e_oe = !we; e_addr = a; e_data = we ? d : '0;
      if (we) shadow[a] = d;
      else begin e_rv1[w] = 1'b1; e_rd1 = shadow[a]; end
      m_ptr = (w + 1) % NREQ;
`ifdef DPRAM_ARB_LOCK_EN
      if (!m_locked && req_lock[w]) begin m_locked = 1; m_owner = w; end
      else if (m_locked && !req_lock[w]) m_locked = 0;
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit lk);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_lock = '0;
  endtask

  task automatic drain();
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] exp;
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 11'(i + 1), '0, 0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({req_ready, mem_chipselect, rsp_valid, rsp_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b cs=%b rsp_valid=%b rsp_data=%h, required all zero",
                 req_ready, mem_chipselect, rsp_valid, rsp_data);
      end
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = '0; exp[seq[k]] = 1'b1;
      checks++;
      if (req_ready !== exp) begin
        errors++; $display("FAIL rr_order[%0d]: ready=%b required %b", k, req_ready, exp);
      end
      checks++;
      if ({mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data} !==
          {e_cs, e_we, e_oe, e_addr, e_data}) begin
        errors++; $display("FAIL rr_mem[%0d]: cs/we/oe=%b%b%b addr=%0d required %b%b%b addr=%0d", k,
                           mem_chipselect, mem_wr_en, mem_outenable, mem_address, e_cs, e_we, e_oe, e_addr);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_write_read();
    clear_reqs();
    set_req(2, 1, 1, 11'd1024, 8'hA5, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_grant: ready=%b required 0100", req_ready); end
    tick();
    clear_reqs();
    set_req(1, 1, 0, 11'd1024, 8'h00, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_grant: ready=%b required 0010", req_ready); end
    checks++;
    if ({mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data} !== {3'b110, 11'd1024, 8'hA5}) begin
      errors++; $display("FAIL wr_cmd: cs/we/oe=%b%b%b addr=%0d data=%h required 110 addr=1024 data=a5",
                         mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data);
    end
    tick();
    clear_reqs();
    @(negedge clk); checks++;
    if ({mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data} !== {3'b101, 11'd1024, 8'h00}) begin
      errors++; $display("FAIL rd_cmd: cs/we/oe=%b%b%b addr=%0d data=%h required 101 addr=1024 data=00",
                         mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data);
    end
    tick();
    @(negedge clk); checks++;
    if ({rsp_valid, rsp_data} !== {4'b0010, 8'hA5}) begin
      errors++; $display("FAIL raw_rsp: rsp_valid=%b rsp_data=%h required 0010 a5", rsp_valid, rsp_data);
    end
    tick();
    drain();
  endtask

  task automatic test_ptr_wrap();
    int seq[3] = '{3, 1, 3};
    logic [NREQ-1:0] exp;
    clear_reqs();
    set_req(2, 1, 0, 11'd5, '0, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup: ready=%b required 0100", req_ready); end
    tick();
    clear_reqs();
    set_req(1, 1, 0, 11'd6, '0, 0);
    set_req(3, 1, 0, 11'd7, '0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = '0; exp[seq[k]] = 1'b1;
      checks++;
      if (req_ready !== exp) begin
        errors++; $display("FAIL wrap_order[%0d]: ready=%b required %b", k, req_ready, exp);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_discard();
    clear_reqs();
    set_req(0, 1, 0, 11'd9, '0, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL disc_g0: ready=%b required 0001", req_ready); end
    tick();
    clear_reqs();
    set_req(1, 1, 0, 11'd10, '0, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL disc_g1: ready=%b required 0010", req_ready); end
    tick();
    clear_reqs();
    reset = 1'b1;
    @(negedge clk); checks++;
    if ({rsp_valid, rsp_data} !== {4'b0001, e_rd2}) begin
      errors++; $display("FAIL disc_first: rsp_valid=%b rsp_data=%h required 0001 %h", rsp_valid, rsp_data, e_rd2);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); checks++;
      if ({rsp_valid, rsp_data} !== '0) begin
        errors++; $display("FAIL disc_flushed[%0d]: rsp_valid=%b rsp_data=%h required 0 0", k, rsp_valid, rsp_data);
      end
      tick();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 11'(20 + i), '0, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL disc_ptr: ready=%b required 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_lock();
    logic [NREQ-1:0] exp1, exp2;
`ifdef DPRAM_ARB_LOCK_EN
    exp1 = 4'b0001; exp2 = 4'b0010;
`else
    exp1 = 4'b0010; exp2 = 4'b0100;
`endif
    clear_reqs();
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(0, 1, 0, 11'd30, '0, 1);
    for (int i = 1; i < NREQ; i++) set_req(i, 1, 0, 11'(30 + i), '0, 0);
    @(negedge clk); checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_first: ready=%b required 0001", req_ready); end
    tick();
    set_req(0, 1, 1, 11'd30, 8'h3C, 0);
    @(negedge clk); checks++;
    if (req_ready !== exp1) begin errors++; $display("FAIL lock_second: ready=%b required %b", req_ready, exp1); end
    tick();
`ifdef DPRAM_ARB_LOCK_EN
    req_valid[0] = 1'b0;
`endif
    @(negedge clk); checks++;
    if (req_ready !== exp2) begin errors++; $display("FAIL lock_third: ready=%b required %b", req_ready, exp2); end
    checks++;
    if ({rsp_valid, rsp_data} !== {4'b0001, e_rd2}) begin
      errors++; $display("FAIL lock_rsp: rsp_valid=%b rsp_data=%h required 0001 %h", rsp_valid, rsp_data, e_rd2);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    int last_w = -1;
    int w;
    int waitc[NREQ];
    int r;
    logic [NREQ-1:0] exp;
    logic [ADDR_W-1:0] a;
    foreach (waitc[i]) waitc[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_w != i)) begin
          r = $urandom_range(0, 9);
          a = (r < 8) ? 11'(r) : ((r == 8) ? 11'd1024 : 11'd2047);
          set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1), a, 8'($urandom),
                  $urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
      w = model_winner();
      exp = '0;
      if (w >= 0) exp[w] = 1'b1;
      checks++;
      if (req_ready !== exp) begin
        errors++; $display("FAIL rnd_ready[%0d]: ready=%b required %b", cyc, req_ready, exp);
      end
      checks++;
      if ({mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data} !==
          {e_cs, e_we, e_oe, e_addr, e_data}) begin
        errors++; $display("FAIL rnd_mem[%0d]: cs/we/oe=%b%b%b addr=%0d data=%h required %b%b%b addr=%0d data=%h",
                           cyc, mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data,
                           e_cs, e_we, e_oe, e_addr, e_data);
      end
      checks++;
      if ({rsp_valid, rsp_data} !== {e_rv2, e_rd2}) begin
        errors++; $display("FAIL rnd_rsp[%0d]: rsp_valid=%b rsp_data=%h required %b %h",
                           cyc, rsp_valid, rsp_data, e_rv2, e_rd2);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !reset && w != i) waitc[i]++;
        else waitc[i] = 0;
`ifndef DPRAM_ARB_LOCK_EN
        checks++;
        if (waitc[i] >= NREQ) begin
          errors++; $display("FAIL rnd_fair[%0d]: requester %0d waited %0d cycles, required < %0d", cyc, i, waitc[i], NREQ);
        end
`endif
      end
      last_w = w;
      tick();
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      logic [DATA_W-1:0] v;
      v = 8'($urandom);
      ram[i] = v;
      shadow[i] = v;
    end
    test_reset();
    test_write_read();
    test_ptr_wrap();
    test_reset_discard();
    test_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
